clock_time_counter: RTL and testbench

- 12-hour time-of-day counter (HH:MM:SS, AM/PM) kept as BCD digits.
- Sits directly upstream of the seven-segment display driver and takes its digits and PM flag.
- Advances on a single-cycle tick pulse from the clock divider.
- Provides a set mode with hour/minute increment buttons for manual time adjustment.

---
 rtl/clock_time_counter.sv | 186 ++++++++++++++++++
 tb/tb_clock_time_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// 12-hour BCD time-of-day counter (HH:MM:SS + PM) with RUN/SET modes; optional 24-hour build via HOUR24_EN.
// Latency: all outputs registered; digits and sec_pulse change the cycle after the qualifying tick/button rise.
// Backpressure: none; tick is consumed every cycle it is high, en=0 or SET mode simply ignores it.
module clock_time_counter #(
    parameter int TICK_DIV = 1,
    parameter bit INIT_PM  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       en,
    input  logic       set_mode,
    input  logic       inc_hr,
    input  logic       inc_min,
`ifdef HOUR24_EN
    output logic [1:0] hr_tens,
`else
    output logic       hr_tens,
`endif
    output logic [3:0] hr_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       pm,
    output logic       sec_pulse,
    output logic       in_set
);

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    localparam logic [9:0] PRESC_LAST = 10'(TICK_DIV - 1);

`ifdef HOUR24_EN
    localparam logic [1:0] HR_TENS_RST = 2'd0;
    localparam logic [3:0] HR_ONES_RST = 4'd0;
    localparam logic       PM_RST      = 1'b0;
`else
    localparam logic       HR_TENS_RST = 1'b1;
    localparam logic [3:0] HR_ONES_RST = 4'd2;
    localparam logic       PM_RST      = INIT_PM;
`endif

    state_t     state;
    logic [9:0] presc;
    logic       inc_hr_prev;
    logic       inc_min_prev;

    logic       run_tick;
    logic       sec_adv;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hr_rise;
    logic       min_rise;
    logic       min_step;
    logic       hr_step;
    logic [9:0] presc_nxt;
    logic [2:0] sec_tens_nxt;
    logic [3:0] sec_ones_nxt;
    logic [2:0] min_tens_nxt;
    logic [3:0] min_ones_nxt;
`ifdef HOUR24_EN
    logic [1:0] hr_tens_nxt;
`else
    logic       hr_tens_nxt;
`endif
    logic [3:0] hr_ones_nxt;
    logic       pm_nxt;

    // Next-state arithmetic: prescaler, second advance, and carry chain sec->min->hour.
    always_comb begin
        run_tick  = (state == RUN) && en && tick;
        sec_adv   = run_tick && (presc == PRESC_LAST);
        sec_wrap  = (sec_tens == 3'd5) && (sec_ones == 4'd9);
        min_wrap  = (min_tens == 3'd5) && (min_ones == 4'd9);
        hr_rise   = inc_hr & ~inc_hr_prev;
        min_rise  = inc_min & ~inc_min_prev;
        // In SET the minute button never carries into the hour; the hour button acts on its own.
        min_step  = (sec_adv && sec_wrap) || ((state == SET) && min_rise);
        hr_step   = (sec_adv && sec_wrap && min_wrap) || ((state == SET) && hr_rise);

        presc_nxt    = presc;
        sec_tens_nxt = sec_tens;
        sec_ones_nxt = sec_ones;
        min_tens_nxt = min_tens;
        min_ones_nxt = min_ones;
        hr_tens_nxt  = hr_tens;
        hr_ones_nxt  = hr_ones;
        pm_nxt       = pm;

        // SET holds seconds and prescaler at zero so RUN restarts with a full interval.
        if (state == SET) begin
            presc_nxt    = 10'd0;
            sec_tens_nxt = 3'd0;
            sec_ones_nxt = 4'd0;
        end else if (run_tick) begin
            presc_nxt = sec_adv ? 10'd0 : presc + 10'd1;
        end

        if (sec_adv) begin
            if (sec_ones == 4'd9) begin
                sec_ones_nxt = 4'd0;
                sec_tens_nxt = (sec_tens == 3'd5) ? 3'd0 : sec_tens + 3'd1;
            end else begin
                sec_ones_nxt = sec_ones + 4'd1;
            end
        end

        if (min_step) begin
            if (min_ones == 4'd9) begin
                min_ones_nxt = 4'd0;
                min_tens_nxt = (min_tens == 3'd5) ? 3'd0 : min_tens + 3'd1;
            end else begin
                min_ones_nxt = min_ones + 4'd1;
            end
        end

`ifdef HOUR24_EN
        pm_nxt = 1'b0;
        if (hr_step) begin
            if ((hr_tens == 2'd2) && (hr_ones == 4'd3)) begin
                hr_tens_nxt = 2'd0;
                hr_ones_nxt = 4'd0;
            end else if (hr_ones == 4'd9) begin
                hr_tens_nxt = hr_tens + 2'd1;
                hr_ones_nxt = 4'd0;
            end else begin
                hr_ones_nxt = hr_ones + 4'd1;
            end
        end
`else
        if (hr_step) begin
            if (hr_tens && (hr_ones == 4'd1)) begin
                // 11 -> 12 is the AM/PM boundary.
                hr_ones_nxt = 4'd2;
                pm_nxt      = ~pm;
            end else if (hr_tens && (hr_ones == 4'd2)) begin
                hr_tens_nxt = 1'b0;
                hr_ones_nxt = 4'd1;
            end else if (hr_ones == 4'd9) begin
                hr_tens_nxt = 1'b1;
                hr_ones_nxt = 4'd0;
            end else begin
                hr_ones_nxt = hr_ones + 4'd1;
            end
        end
`endif
    end

    // State, time digits, button history and pulse registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            in_set       <= 1'b0;
            presc        <= 10'd0;
            inc_hr_prev  <= 1'b0;
            inc_min_prev <= 1'b0;
            sec_pulse    <= 1'b0;
            hr_tens      <= HR_TENS_RST;
            hr_ones      <= HR_ONES_RST;
            min_tens     <= 3'd0;
            min_ones     <= 4'd0;
            sec_tens     <= 3'd0;
            sec_ones     <= 4'd0;
            pm           <= PM_RST;
        end else begin
            state        <= set_mode ? SET : RUN;
            in_set       <= set_mode;
            presc        <= presc_nxt;
            inc_hr_prev  <= inc_hr;
            inc_min_prev <= inc_min;
            sec_pulse    <= sec_adv;
            hr_tens      <= hr_tens_nxt;
            hr_ones      <= hr_ones_nxt;
            min_tens     <= min_tens_nxt;
            min_ones     <= min_ones_nxt;
            sec_tens     <= sec_tens_nxt;
            sec_ones     <= sec_ones_nxt;
            pm           <= pm_nxt;
        end
    end

endmodule

// File: tb/tb_clock_time_counter.sv
module tb_clock_time_counter;

    logic clk = 1'b0;
    logic rst, tick, en, set_mode, inc_hr, inc_min;

    logic       a_hr_tens, a_pm, a_sec_pulse, a_in_set;
    logic [3:0] a_hr_ones, a_min_ones, a_sec_ones;
    logic [2:0] a_min_tens, a_sec_tens;
    logic       b_hr_tens, b_pm, b_sec_pulse, b_in_set;
    logic [3:0] b_hr_ones, b_min_ones, b_sec_ones;
    logic [2:0] b_min_tens, b_sec_tens;

    int tests = 0;
    int fails = 0;
    int pulse_cnt;
    int bad_cnt;

    always #5 clk = ~clk;

    clock_time_counter #(.TICK_DIV(1), .INIT_PM(1'b0)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .en(en), .set_mode(set_mode),
        .inc_hr(inc_hr), .inc_min(inc_min),
        .hr_tens(a_hr_tens), .hr_ones(a_hr_ones), .min_tens(a_min_tens), .min_ones(a_min_ones),
        .sec_tens(a_sec_tens), .sec_ones(a_sec_ones), .pm(a_pm),
        .sec_pulse(a_sec_pulse), .in_set(a_in_set)
    );

    clock_time_counter #(.TICK_DIV(3), .INIT_PM(1'b1)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .en(en), .set_mode(set_mode),
        .inc_hr(inc_hr), .inc_min(inc_min),
        .hr_tens(b_hr_tens), .hr_ones(b_hr_ones), .min_tens(b_min_tens), .min_ones(b_min_ones),
        .sec_tens(b_sec_tens), .sec_ones(b_sec_ones), .pm(b_pm),
        .sec_pulse(b_sec_pulse), .in_set(b_in_set)
    );

    // Time packed as hex digits HH MM SS P, e.g. 28'h1159591 = 11:59:59 PM.
    function automatic logic [27:0] time_a();
        return {3'b0, a_hr_tens, a_hr_ones, 1'b0, a_min_tens, a_min_ones,
                1'b0, a_sec_tens, a_sec_ones, 3'b0, a_pm};
    endfunction

    function automatic logic [27:0] time_b();
        return {3'b0, b_hr_tens, b_hr_ones, 1'b0, b_min_tens, b_min_ones,
                1'b0, b_sec_tens, b_sec_ones, 3'b0, b_pm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs were set before the call, outputs are read 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A tick cycle followed by an idle cycle; tracks dut_a's sec_pulse timing.
    task automatic tick_a();
        tick = 1'b1;
        step();
        if (a_sec_pulse) pulse_cnt++; else bad_cnt++;
        tick = 1'b0;
        step();
        if (a_sec_pulse) bad_cnt++;
    endtask

    task automatic press(input logic hr, input logic mn);
        inc_hr  = hr;
        inc_min = mn;
        step();
        if (a_sec_pulse) bad_cnt++;
        inc_hr  = 1'b0;
        inc_min = 1'b0;
        step();
        if (a_sec_pulse) bad_cnt++;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; en = 1'b0; set_mode = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
        #1;
        step();
        step();
        rst = 1'b0;
        chk("reset_time_a", 32'(time_a()), 32'h1200000);
        chk("reset_time_b", 32'(time_b()), 32'h1200001);
        chk("reset_pulse",  32'(a_sec_pulse), 32'd0);
        chk("reset_in_set", 32'(a_in_set), 32'd0);

        // 61 seconds from reset.
        en = 1'b1;
        pulse_cnt = 0; bad_cnt = 0;
        for (int i = 0; i < 61; i++) tick_a();
        chk("run61_time",   32'(time_a()), 32'h1201010);
        chk("run61_pulses", 32'(pulse_cnt), 32'd61);
        chk("run61_width",  32'(bad_cnt), 32'd0);

        // Enter SET: first edge changes state, next edge clears seconds.
        set_mode = 1'b1;
        step();
        chk("set_enter", 32'(a_in_set), 32'd1);
        step();
        chk("set_sec_clear", 32'(time_a()), 32'h1201000);
        // 23 hour presses from 12 AM -> 11 PM, 58 minute presses 01 -> 59.
        bad_cnt = 0;
        for (int i = 0; i < 58; i++) press(i < 23, 1'b1);
        chk("set_load", 32'(time_a()), 32'h1159001);
        chk("set_no_pulse", 32'(bad_cnt), 32'd0);
        set_mode = 1'b0;
        step();
        chk("set_exit", 32'(a_in_set), 32'd0);
        pulse_cnt = 0; bad_cnt = 0;
        for (int i = 0; i < 58; i++) tick_a();
        chk("pm_5958", 32'(time_a()), 32'h1159581);
        tick_a();
        chk("pm_5959", 32'(time_a()), 32'h1159591);
        tick_a();
        chk("midnight", 32'(time_a()), 32'h1200000);

        // 12:59:59 AM -> 01:00:00 AM.
        set_mode = 1'b1;
        step();
        step();
        for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
        set_mode = 1'b0;
        step();
        for (int i = 0; i < 59; i++) tick_a();
        chk("t125959", 32'(time_a()), 32'h1259590);
        tick_a();
        chk("t010000", 32'(time_a()), 32'h0100000);

        // Prescaler with TICK_DIV=3, preserved across en=0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_time_b", 32'(time_b()), 32'h1200001);
        en = 1'b1;
        tick_a();
        tick_a();
        chk("div_2ticks_b", 32'(time_b()), 32'h1200001);
        chk("div_2ticks_a", 32'(time_a()), 32'h1200020);
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick_a();
        chk("en_low_b", 32'(time_b()), 32'h1200001);
        chk("en_low_a", 32'(time_a()), 32'h1200020);
        en = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("div_adv_b",   32'(time_b()), 32'h1200011);
        chk("div_pulse_b", 32'(b_sec_pulse), 32'd1);
        step();
        chk("div_pulse_end_b", 32'(b_sec_pulse), 32'd0);
        tick_a();
        tick_a();
        chk("div_hold_b", 32'(time_b()), 32'h1200011);
        tick_a();
        chk("div_adv2_b", 32'(time_b()), 32'h1200021);

        // SET at 10:45:00 AM; dut_a is at 12:00:06 AM.
        set_mode = 1'b1;
        step();
        step();
        for (int i = 0; i < 45; i++) press(i < 10, 1'b1);
        chk("set_1045", 32'(time_a()), 32'h1045000);
        inc_hr = 1'b1; inc_min = 1'b1;
        step();
        chk("both_rise", 32'(time_a()), 32'h1146000);
        chk("both_no_pulse", 32'(a_sec_pulse), 32'd0);
        inc_hr = 1'b0; inc_min = 1'b0;
        step();
        inc_min = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("hold_min", 32'(time_a()), 32'h1147000);
        inc_min = 1'b0;
        step();
        bad_cnt = 0;
        tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (a_sec_pulse) bad_cnt++;
        end
        tick = 1'b0;
        chk("set_ticks", 32'(time_a()), 32'h1147000);
        chk("set_ticks_pulse", 32'(bad_cnt), 32'd0);

        // Reset mid-SET with a button held, then release into SET with it still held.
        inc_hr = 1'b1;
        rst = 1'b1;
        step();
        chk("rst_set_a", 32'(time_a()), 32'h1200000);
        chk("rst_set_b", 32'(time_b()), 32'h1200001);
        chk("rst_set_in_set", 32'(a_in_set), 32'd0);
        rst = 1'b0;
        step();
        chk("rel_in_set", 32'(a_in_set), 32'd1);
        chk("rel_no_inc", 32'(time_a()), 32'h1200000);
        step();
        chk("rel_no_inc2", 32'(time_a()), 32'h1200000);
        inc_hr = 1'b0;
        set_mode = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
